// File: rtl/kgp_seq_pkg.sv
// Shared types and constants for the KGP-RISC PC sequencer.
package kgp_seq_pkg;

  // Bytes per instruction word; sequential PC step.
  localparam int unsigned INSTR_BYTES = 4;

  // Low PC bits that are always zero for word-aligned targets.
  localparam int unsigned ALIGN_BITS = 2;

  // Control states, 3-bit encoding.
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } seq_state_e;

  // Next-PC source select.
  typedef enum logic [1:0] {
    SelSeq    = 2'd0,
    SelBranch = 2'd1,
    SelJr     = 2'd2
  } next_sel_e;

  // Priority: register jump (jr/call) over taken branch over sequential.
  function automatic next_sel_e pick_next_sel(input logic is_jr, input logic is_call,
                                              input logic is_branch, input logic br_taken);
    if (is_jr || is_call) begin
      return SelJr;
    end else if (is_branch && br_taken) begin
      return SelBranch;
    end else begin
      return SelSeq;
    end
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC datapath: sequential, PC-relative branch and register-jump targets.
// All arithmetic wraps modulo 2^ADDR_W.
module pc_next_calc
  import kgp_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OFF_W  = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [OFF_W-1:0]  br_off,
  input  logic [ADDR_W-1:0] rs_val,
  input  next_sel_e         sel,
  output logic [ADDR_W-1:0] nxt_pc
);

  localparam int unsigned ExtW = ADDR_W - OFF_W;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] jr_pc;

  // Candidate targets; the word offset is sign-extended then scaled to bytes.
  always_comb begin
    seq_pc  = pc + ADDR_W'(INSTR_BYTES);
    off_ext = {{ExtW{br_off[OFF_W-1]}}, br_off};
    br_pc   = seq_pc + (off_ext << ALIGN_BITS);
    jr_pc   = rs_val & ~ADDR_W'((1 << ALIGN_BITS) - 1);
  end

  // Target mux.
  always_comb begin
    nxt_pc = seq_pc;
    case (sel)
      SelBranch: nxt_pc = br_pc;
      SelJr:     nxt_pc = jr_pc;
      default:   nxt_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// KGP-RISC multi-cycle control FSM and program counter.
// FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH, HALT absorbing until rst.
// Optional feature macro PC_SEQ_LINK_EN: when defined, is_call writes the link register
// (link_we/link_addr in WB); when undefined, is_call behaves like is_jr and the link outputs are 0.
module pc_sequencer
  import kgp_seq_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        OFF_W     = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              dec_valid,
  input  logic              is_branch,
  input  logic              br_taken,
  input  logic              is_jr,
  input  logic              is_call,
  input  logic              is_mem,
  input  logic              is_halt,
  input  logic [OFF_W-1:0]  br_off,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_old,
  output logic              imem_req,
  output logic              ir_we,
  output logic              dmem_req,
  output logic              rf_we,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              halted,
  output logic [31:0]       retired
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_old_q;
  logic [ADDR_W-1:0] nxt_pc_q;
  logic [31:0]       retired_q;
  next_sel_e         sel;
  logic [ADDR_W-1:0] nxt_pc;
`ifdef PC_SEQ_LINK_EN
  logic              call_q;
`endif

  // Select next-PC source from the class flags seen in EXEC.
  always_comb begin
    sel = pick_next_sel(is_jr, is_call, is_branch, br_taken);
  end

  pc_next_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_pc_next_calc (
    .pc     (pc_q),
    .br_off (br_off),
    .rs_val (rs_val),
    .sel    (sel),
    .nxt_pc (nxt_pc)
  );

  // Control FSM with PC, last-retired PC and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= RESET_VEC;
      pc_old_q  <= RESET_VEC;
      nxt_pc_q  <= RESET_VEC;
      retired_q <= '0;
`ifdef PC_SEQ_LINK_EN
      call_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ready) state_q <= StDecode;
        end
        StDecode: begin
          if (!stall && dec_valid) state_q <= is_halt ? StHalt : StExec;
        end
        StExec: begin
          // Target frozen here so later operand changes cannot disturb WB.
          nxt_pc_q <= nxt_pc;
`ifdef PC_SEQ_LINK_EN
          call_q   <= is_call;
`endif
          state_q  <= is_mem ? StMem : StWb;
        end
        StMem: begin
          if (dmem_ready) state_q <= StWb;
        end
        StWb: begin
          pc_q      <= nxt_pc_q;
          pc_old_q  <= pc_q;
          retired_q <= retired_q + 32'd1;
          state_q   <= StFetch;
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StFetch;
        end
      endcase
    end
  end

  // Handshake and write strobes, decoded from state and forced low during reset.
  always_comb begin
    imem_req = !rst && (state_q == StFetch);
    ir_we    = imem_req && imem_ready;
    dmem_req = !rst && (state_q == StMem);
    rf_we    = !rst && (state_q == StWb);
`ifdef PC_SEQ_LINK_EN
    link_we   = rf_we && call_q;
    link_addr = pc_q + ADDR_W'(INSTR_BYTES);
`else
    link_we   = 1'b0;
    link_addr = '0;
`endif
  end

  // Architectural state outputs.
  always_comb begin
    pc      = pc_q;
    pc_old  = pc_old_q;
    retired = retired_q;
    halted  = (state_q == StHalt);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, reset/stall/halt sequences,
// and randomized instructions checked against an arithmetic next-PC model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready, dmem_ready, dec_valid, is_branch, br_taken;
  logic        is_jr, is_call, is_mem, is_halt, stall;
  logic [15:0] br_off;
  logic [31:0] rs_val;
  logic [31:0] pc, pc_old, link_addr, retired;
  logic        imem_req, ir_we, dmem_req, rf_we, link_we, halted;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W    (32),
    .OFF_W     (16),
    .RESET_VEC (32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .dec_valid  (dec_valid),
    .is_branch  (is_branch),
    .br_taken   (br_taken),
    .is_jr      (is_jr),
    .is_call    (is_call),
    .is_mem     (is_mem),
    .is_halt    (is_halt),
    .br_off     (br_off),
    .rs_val     (rs_val),
    .stall      (stall),
    .pc         (pc),
    .pc_old     (pc_old),
    .imem_req   (imem_req),
    .ir_we      (ir_we),
    .dmem_req   (dmem_req),
    .rf_we      (rf_we),
    .link_we    (link_we),
    .link_addr  (link_addr),
    .halted     (halted),
    .retired    (retired)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc;
  logic [31:0] m_retired;

  typedef struct {
    string       name;
    logic        jr, call, br, taken, mem;
    logic [15:0] off;
    logic [31:0] rs;
    int          iw, dw, st;
    logic [31:0] exp_pc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready = 0; dmem_ready = 0; dec_valid = 0; is_branch = 0; br_taken = 0;
    is_jr = 0; is_call = 0; is_mem = 0; is_halt = 0; stall = 0; br_off = '0; rs_val = '0;
  endtask

  // Reference next-PC from the instruction-set rules, plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic jr,
                                             input logic call, input logic br,
                                             input logic taken, input logic [15:0] off,
                                             input logic [31:0] rs);
    int o;
    if (jr || call) return (rs / 4) * 4;
    if (br && taken) begin
      o = int'($signed(off));
      return cur + 32'd4 + 32'(o * 4);
    end
    return cur + 32'd4;
  endfunction

  task automatic no_strobes(input string tag);
    chk({tag, " imem_req"}, imem_req, 0);
    chk({tag, " ir_we"}, ir_we, 0);
    chk({tag, " dmem_req"}, dmem_req, 0);
    chk({tag, " rf_we"}, rf_we, 0);
  endtask

  // Assert rst for two cycles; on release the FSM sits in FETCH.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    #1; no_strobes("rst");
    chk("rst link_we", link_we, 0);
    tick();
    rst = 0;
    #1;
    chk("reset pc", pc, 32'h0);
    chk("reset pc_old", pc_old, 32'h0);
    chk("reset retired", retired, 0);
    chk("reset imem_req", imem_req, 1);
    chk("reset halted", halted, 0);
    m_pc = 32'h0;
    m_retired = 0;
  endtask

  // Drive one instruction from FETCH through WB; entry/exit point is just after a posedge in FETCH.
  task automatic run_instr(input string tag, input logic jr, input logic call, input logic br,
                           input logic taken, input logic mem, input logic [15:0] off,
                           input logic [31:0] rs, input int iw, input int dw, input int st,
                           input logic noise, input logic [31:0] exp_pc);
    logic exp_lw;
    logic [31:0] exp_la;
`ifdef PC_SEQ_LINK_EN
    exp_lw = call;
    exp_la = m_pc + 32'd4;
`else
    exp_lw = 0;
    exp_la = 32'h0;
`endif
    for (int i = 0; i < iw; i++) begin
      imem_ready = 0;
      if (noise) begin stall = 1'($urandom); dmem_ready = 1'($urandom); end
      #1;
      chk({tag, " fetch wait imem_req"}, imem_req, 1);
      chk({tag, " fetch wait ir_we"}, ir_we, 0);
      tick();
    end
    imem_ready = 1;
    #1;
    chk({tag, " fetch imem_req"}, imem_req, 1);
    chk({tag, " fetch ir_we"}, ir_we, 1);
    tick();
    // DECODE
    imem_ready = noise ? 1'($urandom) : 1'b0;
    is_jr = jr; is_call = call; is_branch = br; br_taken = taken; is_mem = mem;
    br_off = off; rs_val = rs; dec_valid = 1;
    if (noise && ($urandom_range(0, 2) == 0)) begin
      dec_valid = 0;
      #1; no_strobes({tag, " dec invalid"});
      tick();
      dec_valid = 1;
    end
    for (int i = 0; i < st; i++) begin
      stall = 1;
      #1; no_strobes({tag, " stall"});
      chk({tag, " stall pc"}, pc, m_pc);
      tick();
    end
    stall = 0;
    #1; no_strobes({tag, " decode"});
    tick();
    // EXEC
    if (noise) stall = 1'($urandom);
    #1; no_strobes({tag, " exec"});
    tick();
    // Operands change after EXEC; the target must already be held.
    rs_val = $urandom; br_off = 16'($urandom); is_call = 0; is_jr = 0;
    is_branch = 1'($urandom); is_mem = 1'($urandom); dec_valid = 0;
    if (mem) begin
      for (int i = 0; i < dw; i++) begin
        dmem_ready = 0;
        if (noise) imem_ready = 1'($urandom);
        #1;
        chk({tag, " mem wait dmem_req"}, dmem_req, 1);
        chk({tag, " mem wait rf_we"}, rf_we, 0);
        tick();
      end
      dmem_ready = 1;
      #1; chk({tag, " mem dmem_req"}, dmem_req, 1);
      tick();
    end
    // WB
    dmem_ready = noise ? 1'($urandom) : 1'b0;
    #1;
    chk({tag, " wb rf_we"}, rf_we, 1);
    chk({tag, " wb dmem_req"}, dmem_req, 0);
    chk({tag, " wb link_we"}, link_we, exp_lw);
    if (exp_lw) chk({tag, " wb link_addr"}, link_addr, exp_la);
    chk({tag, " wb pc"}, pc, m_pc);
    tick();
    clear_inputs();
    #1;
    chk({tag, " pc"}, pc, exp_pc);
    chk({tag, " pc_old"}, pc_old, m_pc);
    chk({tag, " retired"}, retired, m_retired + 1);
    chk({tag, " back to fetch"}, imem_req, 1);
    m_pc = exp_pc;
    m_retired = m_retired + 1;
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    // name, jr, call, br, taken, mem, off, rs, iw, dw, st, exp_pc
    vecs.push_back('{"seq0",    0, 0, 0, 0, 0, 16'h0,    32'h0,        0, 0, 0, 32'h4});
    vecs.push_back('{"seq1",    0, 0, 0, 0, 0, 16'h0,    32'h0,        0, 0, 0, 32'h8});
    vecs.push_back('{"seq2",    0, 0, 0, 0, 0, 16'h0,    32'h0,        0, 0, 0, 32'hC});
    vecs.push_back('{"jr10",    1, 0, 0, 0, 0, 16'h0,    32'h10,       0, 0, 0, 32'h10});
    vecs.push_back('{"br_tk",   0, 0, 1, 1, 0, 16'hFFFE, 32'h0,        0, 0, 0, 32'hC});
    vecs.push_back('{"jr10b",   1, 0, 0, 0, 0, 16'h0,    32'h10,       1, 0, 0, 32'h10});
    vecs.push_back('{"br_nt",   0, 0, 1, 0, 0, 16'hFFFE, 32'h0,        0, 0, 0, 32'h14});
    vecs.push_back('{"mem3",    0, 0, 0, 0, 1, 16'h0,    32'h0,        0, 3, 0, 32'h18});
    vecs.push_back('{"jr103",   1, 0, 0, 0, 0, 16'h0,    32'h103,      0, 0, 0, 32'h100});
    vecs.push_back('{"jr20",    1, 0, 0, 0, 0, 16'h0,    32'h20,       0, 0, 0, 32'h20});
    vecs.push_back('{"call",    0, 1, 0, 0, 0, 16'h0,    32'h40,       0, 0, 0, 32'h40});
    vecs.push_back('{"jrtop",   1, 0, 0, 0, 0, 16'h0,    32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC});
    vecs.push_back('{"wrap",    0, 0, 0, 0, 0, 16'h0,    32'h0,        0, 0, 0, 32'h0});
    vecs.push_back('{"stall5",  0, 0, 0, 0, 0, 16'h0,    32'h0,        2, 0, 5, 32'h4});
    vecs.push_back('{"jr_vs_br", 1, 0, 1, 1, 0, 16'h7,   32'h80,       0, 0, 0, 32'h80});
    vecs.push_back('{"br_fwd",  0, 0, 1, 1, 1, 16'h3,    32'h0,        0, 0, 0, 32'h90});

    clear_inputs();
    do_reset();

    foreach (vecs[k]) begin
      v = vecs[k];
      run_instr(v.name, v.jr, v.call, v.br, v.taken, v.mem, v.off, v.rs, v.iw, v.dw, v.st,
                1'b0, v.exp_pc);
    end

    // Reset while waiting in MEM: no retire, no strobe, back to reset values.
    imem_ready = 1; tick();
    imem_ready = 0; is_mem = 1; dec_valid = 1; tick();
    tick();
    clear_inputs();
    #1; chk("mid-mem dmem_req", dmem_req, 1);
    rst = 1; dmem_ready = 1;
    #1; chk("rst in mem dmem_req", dmem_req, 0);
    chk("rst in mem rf_we", rf_we, 0);
    tick();
    rst = 0; dmem_ready = 0;
    #1;
    chk("rst in mem pc", pc, 32'h0);
    chk("rst in mem pc_old", pc_old, 32'h0);
    chk("rst in mem retired", retired, 0);
    chk("rst in mem fetch", imem_req, 1);
    m_pc = 0; m_retired = 0;

    // Randomized instructions against the model.
    for (int n = 0; n < 40; n++) begin
      logic jr, call, br, tk, mem;
      logic [15:0] off;
      logic [31:0] rs;
      jr   = ($urandom_range(0, 5) == 0);
      call = ($urandom_range(0, 7) == 0);
      br   = ($urandom_range(0, 2) == 0);
      tk   = 1'($urandom);
      mem  = ($urandom_range(0, 2) == 0);
      off  = 16'($urandom);
      rs   = $urandom;
      run_instr($sformatf("rnd%0d", n), jr, call, br, tk, mem, off, rs,
                $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1,
                model_next(m_pc, jr, call, br, tk, off, rs));
    end

    // Halt beats every other class flag and freezes the machine.
    imem_ready = 1; tick();
    imem_ready = 0; dec_valid = 1; is_halt = 1; is_jr = 1; is_mem = 1; rs_val = 32'h500;
    #1; no_strobes("halt decode");
    tick();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1'($urandom); dmem_ready = 1'($urandom); dec_valid = 1;
      #1;
      chk("halt halted", halted, 1);
      chk("halt pc", pc, m_pc);
      chk("halt retired", retired, m_retired);
      no_strobes("halt");
      tick();
    end
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
